mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//  Parametrised N-input word multiplexer with a registered output and a
//  2-entry valid/ready skid buffer. Drop-in pipeline-stage successor to the
//  fixed 3:1 combinational muxes in the datapath: it selects forwarding or
//  writeback sources and absorbs downstream stalls without losing data.
//  Adds out-of-range select detection, flush and an error counter.
// PARAMETERS
//  WIDTH     32  data word width in bits
//  N         3   number of input words, 2..16
//  SEL_W     2   select width; must satisfy 2**SEL_W >= N
//  BAD_VAL   0   word emitted when select_i >= N (WIDTH bits)
//  CNT_W     8   width of the saturating illegal-select counter
// PORTS
//  clk_i      in   1        clock, rising edge
//  rst_i      in   1        reset, asynchronous, active-high
//  data_i     in   N*WIDTH  packed inputs; word k = data_i[k*WIDTH +: WIDTH]
//  select_i   in   SEL_W    index of word to forward
//  valid_i    in   1        upstream word/select valid
//  ready_o    out  1        stage can accept this cycle
//  flush_i    in   1        discard all held and incoming words
//  data_o     out  WIDTH    selected word, registered
//  valid_o    out  1        data_o valid
//  ready_i    in   1        downstream accepts data_o
//  sel_err_o  out  1        pulses 1 cycle after an accepted illegal select
//  err_cnt_o  out  CNT_W    count of accepted illegal selects, saturating
// BEHAVIOUR
//  Reset (async, any time): main/skid entries invalid; valid_o=0, data_o=0,
//   ready_o=1, sel_err_o=0, err_cnt_o=0. In-flight words are lost.
//  Accept: input taken on a rising edge when valid_i && ready_o.
//   Output taken when valid_o && ready_i.
//  Selection: sel_word = (select_i < N) ? word[select_i] : BAD_VAL.
//   Evaluated at acceptance; later changes to data_i/select_i have no effect.
//  Storage states (main=M, skid=S):
//   EMPTY (M=0,S=0): accept -> ONE.
//   ONE   (M=1,S=0): accept&pop -> ONE (M refilled); pop only -> EMPTY;
//                    accept w/o pop -> FULL (new word into S).
//   FULL  (M=1,S=1): pop -> ONE (S moves to M); no accept possible.
//  ready_o = !S, from a register; no combinational path ready_i->ready_o.
//  Latency: accepted word appears on data_o/valid_o the next cycle when
//   M was empty or popped that cycle. Throughput 1 word/cycle while ready_i=1.
//  Ordering: strictly FIFO; the skid word never overtakes the main word.
//  valid_o/data_o stable while valid_o && !ready_i (no retraction).
//  Flush: at the next edge M and S are invalidated and ready_o=1; an input
//   presented on the flush cycle is discarded and not error-counted.
//   Flush has priority over accept and pop; error counter is preserved.
//  Errors: an accepted select >= N sets sel_err_o=1 for the next cycle only
//   and increments err_cnt_o; counter saturates at 2**CNT_W-1.
//   The BAD_VAL word is still delivered downstream like any other word.
//  N=2**SEL_W: out-of-range is impossible; sel_err_o remains 0.
// TESTING
//  1 Reset: hold rst_i=1 -> valid_o=0, ready_o=1, err_cnt_o=0; assert rst_i
//    mid-stream with 2 held words -> outputs clear immediately, not on edge.
//  2 Streaming, N=3, WIDTH=32, ready_i=1: sel 0,1,2 on inputs
//    {A,B,C}={0x11,0x22,0x33} -> data_o 0x11,0x22,0x33 on cycles 1,2,3.
//  3 Backpressure: ready_i=0, send 0xA then 0xB -> ready_o=0 after 2nd;
//    3rd word held off; ready_i=1 -> 0xA then 0xB, no loss or duplication.
//  4 Illegal select: select_i=3, N=3, BAD_VAL=0xDEAD -> data_o=0xDEAD,
//    sel_err_o pulses one cycle, err_cnt_o=1; 300 illegal selects with
//    CNT_W=8 -> err_cnt_o=255.
//  5 Flush with FULL buffer plus valid_i=1 -> next cycle valid_o=0,
//    ready_o=1, err_cnt_o unchanged even if the flushed select was illegal.
//  6 Random valid_i/ready_i/select_i for 10k cycles vs reference queue model:
//    output order and values match; ready_o never 0 while S empty.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input word multiplexer feeding a 2-entry valid/ready skid buffer.
// The selected word is captured on acceptance and delivered in strict FIFO order.
// Out-of-range selects deliver BAD_VAL, pulse sel_err_o and bump a saturating counter.
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   data_i              N packed words, word k = data_i[k*WIDTH +: WIDTH]
//   select_i            index of the word to forward
//   valid_i / ready_o   upstream handshake (ready_o is registered)
//   flush_i             discard held and incoming words
//   data_o / valid_o    registered output word and its valid
//   ready_i             downstream accepts data_o
//   sel_err_o           one-cycle pulse after an accepted illegal select
//   err_cnt_o           saturating count of accepted illegal selects
module mux_n_pipe #(
    parameter int unsigned           WIDTH   = 32,
    parameter int unsigned           N       = 3,
    parameter int unsigned           SEL_W   = 2,
    parameter logic [WIDTH-1:0]      BAD_VAL = '0,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N*WIDTH-1:0]   data_i,
    input  logic [SEL_W-1:0]     select_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 sel_err_o,
    output logic [CNT_W-1:0]     err_cnt_o
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_legal;
    logic             accept;
    logic             pop;

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             ready_q, ready_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Word selection; anything not matching a real input falls back to BAD_VAL.
    always_comb begin
        sel_word  = BAD_VAL;
        sel_legal = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (select_i == SEL_W'(k)) begin
                sel_word  = data_i[k*WIDTH +: WIDTH];
                sel_legal = 1'b1;
            end
        end
    end

    assign accept = valid_i & ready_q;
    assign pop    = m_valid_q & ready_i;

    // Next-state for main/skid storage and error reporting; flush overrides everything.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        sel_err_d = 1'b0;
        err_cnt_d = err_cnt_q;

        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            if (accept && !sel_legal) begin
                sel_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end

            if (!m_valid_q) begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = sel_word;
                end
            end else if (!s_valid_q) begin
                if (pop && accept) begin
                    m_data_d = sel_word;
                end else if (pop) begin
                    m_valid_d = 1'b0;
                end else if (accept) begin
                    s_valid_d = 1'b1;
                    s_data_d  = sel_word;
                end
            end else if (pop) begin
                // Skid word moves up behind the departing main word.
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end

        // ready_o depends only on next skid occupancy, never on ready_i this cycle.
        ready_d = !s_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
            ready_q   <= 1'b1;
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
            ready_q   <= ready_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_o    = m_data_q;
    assign valid_o   = m_valid_q;
    assign ready_o   = ready_q;
    assign sel_err_o = sel_err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Testbench for mux_n_pipe (N=3, WIDTH=32, BAD_VAL=0xDEAD, CNT_W=8).
// Stimulus pushes expected words into a queue; a negedge monitor pops and compares.
module tb_mux_n_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [95:0] data_i = '0;
    logic [1:0]  select_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        sel_err_o;
    logic [7:0]  err_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    logic        pend_v = 1'b0;
    logic        pend_flush = 1'b0;
    logic        pend_bad = 1'b0;
    logic [31:0] pend_word = '0;
    int          exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    mux_n_pipe #(
        .WIDTH(32), .N(3), .SEL_W(2), .BAD_VAL(32'hDEAD), .CNT_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .sel_err_o(sel_err_o), .err_cnt_o(err_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: retire last cycle's accept into the model, check, then drive new inputs.
    task automatic step(input logic v, input logic [1:0] sel, input logic [95:0] d,
                        input logic rdy, input logic fl);
        logic exp_err;
        @(posedge clk_i);
        #1;
        exp_err = 1'b0;
        if (pend_flush) begin
            q.delete();
        end else if (pend_v) begin
            q.push_back(pend_word);
            if (pend_bad) begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
        if (!rst_i) begin
            check("ready_o", 64'(ready_o), 64'(q.size() < 2));
            check("sel_err_o", 64'(sel_err_o), 64'(exp_err));
            check("err_cnt_o", 64'(err_cnt_o), 64'(exp_cnt));
        end
        pend_v     = v && ready_o && !fl;
        pend_flush = fl;
        pend_bad   = (int'(sel) >= 3);
        pend_word  = (int'(sel) < 3) ? d[int'(sel)*32 +: 32] : 32'hDEAD;
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        ready_i  = rdy;
        flush_i  = fl;
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_sel_err", 64'(sel_err_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        q.delete();
        pend_v = 1'b0;
        pend_flush = 1'b0;
        exp_cnt = 0;
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: valid_o must track model occupancy; every transfer pops and compares.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("valid_o", 64'(valid_o), 64'(q.size() != 0));
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", data_o, $time);
                end else begin
                    check("data_o", 64'(data_o), 64'(q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] d;
        logic        fl;
        logic        rdy;
        d = {32'h33, 32'h22, 32'h11};

        // Held reset
        repeat (3) @(posedge clk_i);
        #1;
        check("init_valid_o", 64'(valid_o), 64'd0);
        check("init_ready_o", 64'(ready_o), 64'd1);
        check("init_err_cnt", 64'(err_cnt_o), 64'd0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;

        // Streaming: one word per cycle, one-cycle latency
        step(1'b1, 2'd0, d, 1'b1, 1'b0);
        step(1'b1, 2'd1, d, 1'b1, 1'b0);
        check("stream_c1", 64'(data_o), 64'h11);
        step(1'b1, 2'd2, d, 1'b1, 1'b0);
        check("stream_c2", 64'(data_o), 64'h22);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("stream_c3", 64'(data_o), 64'h33);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);

        // Backpressure: 0xA then 0xB fill the buffer, 0xC held off
        step(1'b1, 2'd0, {32'h0, 32'h0, 32'hA}, 1'b0, 1'b0);
        step(1'b1, 2'd0, {32'h0, 32'h0, 32'hB}, 1'b0, 1'b0);
        step(1'b1, 2'd0, {32'h0, 32'h0, 32'hC}, 1'b0, 1'b0);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        check("bp_hold_a", 64'(data_o), 64'hA);
        step(1'b1, 2'd0, {32'h0, 32'h0, 32'hC}, 1'b0, 1'b0);
        check("bp_still_a", 64'(data_o), 64'hA);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("bp_then_b", 64'(data_o), 64'hB);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Mid-stream reset with two held words
        step(1'b1, 2'd0, d, 1'b0, 1'b0);
        step(1'b1, 2'd1, d, 1'b0, 1'b0);
        step(1'b0, 2'd0, d, 1'b0, 1'b0);
        do_reset();

        // Single illegal select
        step(1'b1, 2'd3, d, 1'b1, 1'b0);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("ill_data", 64'(data_o), 64'hDEAD);
        check("ill_pulse", 64'(sel_err_o), 64'd1);
        check("ill_cnt", 64'(err_cnt_o), 64'd1);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("ill_pulse_end", 64'(sel_err_o), 64'd0);

        // Flush with one held word and an accepted-looking illegal input
        step(1'b1, 2'd0, d, 1'b0, 1'b0);
        step(1'b1, 2'd3, d, 1'b0, 1'b1);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("flush1_valid", 64'(valid_o), 64'd0);
        check("flush1_ready", 64'(ready_o), 64'd1);
        check("flush1_cnt", 64'(err_cnt_o), 64'd1);
        // Flush with the buffer full
        step(1'b1, 2'd0, d, 1'b0, 1'b0);
        step(1'b1, 2'd1, d, 1'b0, 1'b0);
        step(1'b1, 2'd3, d, 1'b0, 1'b1);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("flush2_valid", 64'(valid_o), 64'd0);
        check("flush2_ready", 64'(ready_o), 64'd1);
        check("flush2_cnt", 64'(err_cnt_o), 64'd1);

        // Saturation
        for (int i = 0; i < 300; i++) step(1'b1, 2'd3, d, 1'b1, 1'b0);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("sat_cnt", 64'(err_cnt_o), 64'd255);

        // Randomized traffic against the queue model
        step(1'b0, 2'd0, d, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            fl  = ($urandom_range(0, 63) == 0);
            rdy = fl ? 1'b0 : ($urandom_range(0, 2) != 0);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom}, rdy, fl);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, d, 1'b1, 1'b0);
        check("final_drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
